control_sequencer: RTL and testbench
====================================

// Module: control_sequencer
// PURPOSE
//  Control unit FSM that drives the datapath: fetches IR, decodes opcode IR[31:27], and issues per-step
//  strobes including Gra/Grb/Grc, Rin, Rout, BAout that the register select/encode logic consumes.
//  One instruction = fixed T-step sequence; supports ld, ldi, st, R-type ALU, I-type ALU, nop, halt.
// PARAMETERS
//  IR_W         32  instruction width
//  OP_W          5  opcode width (IR[31:27])
//  MEM_TIMEOUT  16  max wait cycles for mem_ready (only with CTRL_MEM_WAIT_EN)
// PORTS
//  clock      in   1     system clock, all state on rising edge
//  reset_n    in   1     synchronous active-low reset
//  IR         in   32    current instruction register contents
//  mem_ready  in   1     memory handshake: read data valid / write accepted
//  stop       in   1     halt request, honoured at next fetch boundary
//  PCout,PCin,IncPC,MARin,MDRin,MDRout,IRin,Yin,Zin,Zlowout,Cout  out 1 each  datapath strobes
//  Read,Write out  1     memory strobes
//  Gra,Grb,Grc,Rin,Rout,BAout  out 1 each  register select/direction to select/encode stage
//  alu_op     out  5     ALU operation (opcode encoding; 00011 = ADD)
//  run        out  1     1 while not halted
//  mem_err    out  1     sticky: memory timeout occurred (0 when feature compiled out)
// BEHAVIOUR
//  - Moore outputs decoded from state register; reset_n=0 at edge -> state RST (all outputs 0, run=0),
//    mem_err cleared, wait counter 0. Next edge -> T0. Reset mid-instruction abandons it.
//  - Fetch: T0 PCout,MARin,IncPC,Zin | T1 Zlowout,PCin,Read,MDRin | T2 MDRout,IRin.
//  - R-type (00011..01011): T3 Grb,Rout,Yin | T4 Grc,Rout,Zin,alu_op=op | T5 Zlowout,Gra,Rin -> T0.
//  - I-type addi/andi/ori (01100..01110): T3 Grb,Rout,Yin | T4 Cout,Zin,alu_op=add/and/or | T5 Zlowout,Gra,Rin.
//  - ldi (00001): T3 Grb,BAout,Yin | T4 Cout,Zin,alu_op=ADD | T5 Zlowout,Gra,Rin.
//  - ld (00000): T3-T4 as ldi | T5 Zlowout,MARin | T6 Read,MDRin | T7 MDRout,Gra,Rin.
//  - st (00010): T3-T5 as ld | T6 Gra,Rout,MDRin (Read=0) | T7 Write.
//  - nop (11010) and undefined opcodes: return to T0 after T2. halt (11011): -> HALT.
//  - HALT: all strobes 0, run=0, exit only via reset. stop=1 sampled in T2 -> HALT instead of T3
//    (current instruction not executed); stop elsewhere has no effect until next T2.
//  - Never more than one of Gra/Grb/Grc high; never Rin and Rout high in same state.
//  - Read/Write states (T1, ld T6, st T7) are single-cycle without the feature.
// CONFIGURATION
//  CTRL_MEM_WAIT_EN defined: Read/Write states hold (outputs stable) until mem_ready=1, then advance;
//    wait counter counts held cycles; reaching MEM_TIMEOUT without mem_ready -> HALT, mem_err=1.
//    mem_ready and timeout same edge: mem_ready wins.
//  Not defined: mem_ready ignored, memory states last exactly 1 cycle, mem_err tied 0.
// STRUCTURE
//  ctrl_pkg: opcode localparams, ALU op codes, state encoding (RST,T0..T7,HALT), opcode class enum.
//  Sub-module ctrl_op_class: combinational opcode -> class {LD,LDI,ST,RTYPE,ITYPE,NOP,HALT} + alu_op.
//  Top: state register, next-state logic, output decode, optional wait counter.
// TESTING
//  1 reset_n=0 two cycles, release -> RST outputs all 0, T0 next cycle with PCout=MARin=IncPC=Zin=1.
//  2 IR=add r3,r1,r2 (0x19888000) -> T3 Grb+Rout, T4 Grc+Rout alu_op=00011, T5 Gra+Rin; 6 cycles total.
//  3 IR=ld r2,0x95(r0) -> T3 Grb+BAout, T6 Read, T7 Gra+Rin; back in T0 on cycle 9.
//  4 IR=st, mem_ready held low 3 cycles in T7 (feature on) -> Write held 4 cycles, then T0; mem_err=0.
//  5 mem_ready never asserted in T1 (feature on) -> HALT after 16 waits, mem_err=1, run=0.
//  6 stop=1 in T2 -> HALT next cycle, no Rin pulse; reset_n=0 during T4 -> RST, then clean fetch.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ============================================================================
// Module : ctrl_pkg
// Brief  : Opcode, ALU and state encodings shared by the control sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package ctrl_pkg;

    localparam logic [4:0] c_op_ld   = 5'b00000;
    localparam logic [4:0] c_op_ldi  = 5'b00001;
    localparam logic [4:0] c_op_st   = 5'b00010;
    localparam logic [4:0] c_op_add  = 5'b00011;
    localparam logic [4:0] c_op_rol  = 5'b01011;
    localparam logic [4:0] c_op_addi = 5'b01100;
    localparam logic [4:0] c_op_andi = 5'b01101;
    localparam logic [4:0] c_op_ori  = 5'b01110;
    localparam logic [4:0] c_op_nop  = 5'b11010;
    localparam logic [4:0] c_op_halt = 5'b11011;

    // ALU codes reuse the R-type opcode of the matching operation
    localparam logic [4:0] c_alu_add = 5'b00011;
    localparam logic [4:0] c_alu_and = 5'b00101;
    localparam logic [4:0] c_alu_or  = 5'b00110;

    typedef enum logic [3:0] {
        ST_RST  = 4'd0,
        ST_T0   = 4'd1,
        ST_T1   = 4'd2,
        ST_T2   = 4'd3,
        ST_T3   = 4'd4,
        ST_T4   = 4'd5,
        ST_T5   = 4'd6,
        ST_T6   = 4'd7,
        ST_T7   = 4'd8,
        ST_HALT = 4'd9
    } state_t;

    typedef enum logic [2:0] {
        CL_LD    = 3'd0,
        CL_LDI   = 3'd1,
        CL_ST    = 3'd2,
        CL_RTYPE = 3'd3,
        CL_ITYPE = 3'd4,
        CL_NOP   = 3'd5,
        CL_HALT  = 3'd6
    } op_class_t;

endpackage

`default_nettype wire

// File: rtl/ctrl_op_class.sv
// ============================================================================
// Module : ctrl_op_class
// Brief  : Combinational opcode classifier; yields instruction class and ALU op.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ctrl_op_class
    import ctrl_pkg::*;
(
    input  logic [4:0] i_opcode,
    output op_class_t  o_class,
    output logic [4:0] o_alu_op
);

    always_comb begin
        o_class  = CL_NOP;
        o_alu_op = c_alu_add;
        if (i_opcode >= c_op_add && i_opcode <= c_op_rol) begin
            o_class  = CL_RTYPE;
            o_alu_op = i_opcode;
        end else begin
            case (i_opcode)
                c_op_ld:   o_class = CL_LD;
                c_op_ldi:  o_class = CL_LDI;
                c_op_st:   o_class = CL_ST;
                c_op_addi: o_class = CL_ITYPE;
                c_op_andi: begin o_class = CL_ITYPE; o_alu_op = c_alu_and; end
                c_op_ori:  begin o_class = CL_ITYPE; o_alu_op = c_alu_or;  end
                c_op_halt: o_class = CL_HALT;
                default:   o_class = CL_NOP;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/control_sequencer.sv
// ============================================================================
// Module : control_sequencer
// Brief  : T-step control FSM issuing datapath strobes; optional memory wait
//          with timeout enabled by defining CTRL_MEM_WAIT_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module control_sequencer
    import ctrl_pkg::*;
#(
    parameter int IR_W        = 32,
    parameter int OP_W        = 5,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [IR_W-1:0] IR,
    input  logic            mem_ready,
    input  logic            stop,
    output logic            PCout,
    output logic            PCin,
    output logic            IncPC,
    output logic            MARin,
    output logic            MDRin,
    output logic            MDRout,
    output logic            IRin,
    output logic            Yin,
    output logic            Zin,
    output logic            Zlowout,
    output logic            Cout,
    output logic            Read,
    output logic            Write,
    output logic            Gra,
    output logic            Grb,
    output logic            Grc,
    output logic            Rin,
    output logic            Rout,
    output logic            BAout,
    output logic [4:0]      alu_op,
    output logic            run,
    output logic            mem_err
);

    state_t     r_state;
    state_t     w_next;
    op_class_t  w_class;
    logic [4:0] w_alu;
    logic       w_hold;
    logic       w_timeout;
    logic       w_memop;

    ctrl_op_class u_op_class (
        .i_opcode (IR[IR_W-1 -: OP_W]),
        .o_class  (w_class),
        .o_alu_op (w_alu)
    );

    assign w_memop = (w_class == CL_LD) || (w_class == CL_ST);

`ifdef CTRL_MEM_WAIT_EN
    localparam int c_cnt_w = $clog2(MEM_TIMEOUT + 1);

    logic [c_cnt_w-1:0] r_wait_cnt;
    logic               r_mem_err;
    logic               w_mem_state;
    logic               w_unused;

    assign w_mem_state = (r_state == ST_T1)
                      || (r_state == ST_T6 && w_class == CL_LD)
                      || (r_state == ST_T7 && w_class == CL_ST);
    assign w_hold      = w_mem_state && !mem_ready;
    assign w_timeout   = w_hold && (r_wait_cnt == c_cnt_w'(MEM_TIMEOUT - 1));
    assign mem_err     = r_mem_err;
    assign w_unused    = ^IR[IR_W-OP_W-1:0];

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            r_wait_cnt <= (w_hold && !w_timeout) ? r_wait_cnt + 1'b1 : '0;
            if (w_timeout)
                r_mem_err <= 1'b1;
        end
    end
`else
    logic w_unused;

    assign w_hold    = 1'b0;
    assign w_timeout = 1'b0;
    assign mem_err   = 1'b0;
    assign w_unused  = ^{IR[IR_W-OP_W-1:0], mem_ready, MEM_TIMEOUT[0]};
`endif

    always_ff @(posedge clock) begin
        if (!reset_n)
            r_state <= ST_RST;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_RST:  w_next = ST_T0;
            ST_T0:   w_next = ST_T1;
            ST_T1:   w_next = ST_T2;
            // stop is only honoured here, so the pending instruction never starts
            ST_T2: begin
                if (stop || w_class == CL_HALT) w_next = ST_HALT;
                else if (w_class == CL_NOP)     w_next = ST_T0;
                else                            w_next = ST_T3;
            end
            ST_T3:   w_next = ST_T4;
            ST_T4:   w_next = ST_T5;
            ST_T5:   w_next = w_memop ? ST_T6 : ST_T0;
            ST_T6:   w_next = ST_T7;
            ST_T7:   w_next = ST_T0;
            ST_HALT: w_next = ST_HALT;
            default: w_next = ST_RST;
        endcase
        if (w_timeout)   w_next = ST_HALT;
        else if (w_hold) w_next = r_state;
    end

    always_comb begin
        PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0; MDRin = 1'b0;
        MDRout = 1'b0; IRin = 1'b0; Yin = 1'b0; Zin = 1'b0; Zlowout = 1'b0;
        Cout = 1'b0; Read = 1'b0; Write = 1'b0; Gra = 1'b0; Grb = 1'b0;
        Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0; alu_op = 5'd0;
        run = (r_state != ST_RST) && (r_state != ST_HALT);
        case (r_state)
            ST_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
            ST_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
            ST_T2: begin MDRout = 1'b1; IRin = 1'b1; end
            ST_T3: begin
                Grb = 1'b1;
                Yin = 1'b1;
                if (w_class == CL_RTYPE || w_class == CL_ITYPE) Rout  = 1'b1;
                else                                            BAout = 1'b1;
            end
            ST_T4: begin
                Zin    = 1'b1;
                alu_op = w_alu;
                if (w_class == CL_RTYPE) begin Grc = 1'b1; Rout = 1'b1; end
                else                     Cout = 1'b1;
            end
            ST_T5: begin
                Zlowout = 1'b1;
                if (w_memop) MARin = 1'b1;
                else begin Gra = 1'b1; Rin = 1'b1; end
            end
            ST_T6: begin
                MDRin = 1'b1;
                if (w_class == CL_ST) begin Gra = 1'b1; Rout = 1'b1; end
                else                  Read = 1'b1;
            end
            ST_T7: begin
                if (w_class == CL_ST) Write = 1'b1;
                else begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_control_sequencer.sv
// ============================================================================
// Module : tb_control_sequencer
// Brief  : Scoreboard bench for control_sequencer (directed instruction vectors).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] ir = 32'd0;
    logic        mem_ready = 1'b0;
    logic        stop = 1'b0;
    logic PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Cout;
    logic Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, run, mem_err;
    logic [4:0] alu_op;

    always #5 clk = ~clk;

    control_sequencer dut (
        .clock(clk), .reset_n(reset_n), .IR(ir), .mem_ready(mem_ready), .stop(stop),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
        .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout), .Cout(Cout),
        .Read(Read), .Write(Write), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin),
        .Rout(Rout), .BAout(BAout), .alu_op(alu_op), .run(run), .mem_err(mem_err)
    );

    // Packed view: {19 strobes, alu_op, run, mem_err}
    localparam logic [25:0] E_PCOUT = 26'd1 << 25, E_PCIN  = 26'd1 << 24, E_INCPC = 26'd1 << 23;
    localparam logic [25:0] E_MARIN = 26'd1 << 22, E_MDRIN = 26'd1 << 21, E_MDROUT = 26'd1 << 20;
    localparam logic [25:0] E_IRIN  = 26'd1 << 19, E_YIN   = 26'd1 << 18, E_ZIN   = 26'd1 << 17;
    localparam logic [25:0] E_ZLO   = 26'd1 << 16, E_COUT  = 26'd1 << 15, E_READ  = 26'd1 << 14;
    localparam logic [25:0] E_WRITE = 26'd1 << 13, E_GRA   = 26'd1 << 12, E_GRB   = 26'd1 << 11;
    localparam logic [25:0] E_GRC   = 26'd1 << 10, E_RIN   = 26'd1 << 9,  E_ROUT  = 26'd1 << 8;
    localparam logic [25:0] E_BAOUT = 26'd1 << 7,  E_RUN   = 26'd1 << 1,  E_ERR   = 26'd1;
    localparam logic [25:0] A_ADD = 26'd3 << 2, A_SUB = 26'd4 << 2;
    localparam logic [25:0] A_AND = 26'd5 << 2, A_OR  = 26'd6 << 2;

    localparam logic [25:0] X_T0 = E_PCOUT | E_MARIN | E_INCPC | E_ZIN | E_RUN;
    localparam logic [25:0] X_T1 = E_ZLO | E_PCIN | E_READ | E_MDRIN | E_RUN;
    localparam logic [25:0] X_T2 = E_MDROUT | E_IRIN | E_RUN;
    localparam logic [25:0] X_T3R = E_GRB | E_ROUT | E_YIN | E_RUN;
    localparam logic [25:0] X_T3B = E_GRB | E_BAOUT | E_YIN | E_RUN;
    localparam logic [25:0] X_T4I = E_COUT | E_ZIN | E_RUN;
    localparam logic [25:0] X_T4R = E_GRC | E_ROUT | E_ZIN | E_RUN;
    localparam logic [25:0] X_WB  = E_ZLO | E_GRA | E_RIN | E_RUN;
    localparam logic [25:0] X_T5M = E_ZLO | E_MARIN | E_RUN;

    localparam logic [31:0] I_ADD  = 32'h19888000;  // add r3,r1,r2
    localparam logic [31:0] I_SUB  = 32'h21888000;
    localparam logic [31:0] I_ANDI = 32'h6888000F;
    localparam logic [31:0] I_ORI  = 32'h70880030;
    localparam logic [31:0] I_LDI  = 32'h08800005;
    localparam logic [31:0] I_LD   = 32'h01000095;  // ld r2,0x95(r0)
    localparam logic [31:0] I_ST   = 32'h10800020;
    localparam logic [31:0] I_NOP  = 32'hD0000000;
    localparam logic [31:0] I_UND  = 32'hF8000000;
    localparam logic [31:0] I_HALT = 32'hD8000000;

`ifdef CTRL_MEM_WAIT_EN
    localparam logic RDY = 1'b1;
`else
    localparam logic RDY = 1'b0;
`endif

    typedef struct {
        logic [25:0] v;
        string       nm;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    initial begin : monitor
        exp_t        e;
        logic [25:0] act;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e   = q.pop_front();
                act = {PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout,
                       Cout, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, alu_op, run, mem_err};
                n_cmp++;
                if (act !== e.v) begin
                    n_bad++;
                    $display("FAIL %s: got %07h expected %07h", e.nm, act, e.v);
                end
            end
        end
    end

    // Drive inputs for the next edge and queue the outputs expected after it
    task automatic cyc(input logic rn, input logic st, input logic rd,
                       input logic [31:0] ins, input logic [25:0] ev, input string nm);
        exp_t e;
        @(negedge clk);
        #1;
        reset_n   = rn;
        stop      = st;
        mem_ready = rd;
        ir        = ins;
        e.v  = ev;
        e.nm = nm;
        q.push_back(e);
    endtask

    task automatic step(input logic [31:0] ins, input logic [25:0] ev, input string nm);
        cyc(1'b1, 1'b0, RDY, ins, ev, nm);
    endtask

    task automatic fetch(input logic [31:0] ins, input string nm);
        step(ins, X_T1, {nm, "_t1"});
        step(ins, X_T2, {nm, "_t2"});
    endtask

    task automatic alu_instr(input logic [31:0] ins, input logic [25:0] t3,
                             input logic [25:0] t4, input string nm);
        fetch(ins, nm);
        step(ins, t3,   {nm, "_t3"});
        step(ins, t4,   {nm, "_t4"});
        step(ins, X_WB, {nm, "_t5"});
        step(ins, X_T0, {nm, "_t0"});
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        cyc(1'b0, 1'b0, RDY, 32'd0, 26'd0, "rst_a");
        cyc(1'b0, 1'b0, RDY, 32'd0, 26'd0, "rst_b");
        step(I_NOP, X_T0, "rst_release_t0");

        alu_instr(I_ADD,  X_T3R, X_T4R | A_ADD, "add");
        alu_instr(I_SUB,  X_T3R, X_T4R | A_SUB, "sub");
        alu_instr(I_ANDI, X_T3R, X_T4I | A_AND, "andi");
        alu_instr(I_ORI,  X_T3R, X_T4I | A_OR,  "ori");
        alu_instr(I_LDI,  X_T3B, X_T4I | A_ADD, "ldi");

        fetch(I_LD, "ld");
        step(I_LD, X_T3B,          "ld_t3");
        step(I_LD, X_T4I | A_ADD,  "ld_t4");
        step(I_LD, X_T5M,          "ld_t5");
        step(I_LD, E_READ | E_MDRIN | E_RUN,         "ld_t6");
        step(I_LD, E_MDROUT | E_GRA | E_RIN | E_RUN, "ld_t7");
        step(I_LD, X_T0,           "ld_t0");

        fetch(I_ST, "st");
        step(I_ST, X_T3B,          "st_t3");
        step(I_ST, X_T4I | A_ADD,  "st_t4");
        step(I_ST, X_T5M,          "st_t5");
        step(I_ST, E_GRA | E_ROUT | E_MDRIN | E_RUN, "st_t6");
        step(I_ST, E_WRITE | E_RUN, "st_t7");
`ifdef CTRL_MEM_WAIT_EN
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 1'b0, 1'b0, I_ST, E_WRITE | E_RUN, "st_t7_hold");
        cyc(1'b1, 1'b0, 1'b1, I_ST, X_T0, "st_wait_t0");
`else
        step(I_ST, X_T0, "st_t0");
`endif

        fetch(I_NOP, "nop");
        step(I_NOP, X_T0, "nop_t0");
        fetch(I_UND, "undef");
        step(I_UND, X_T0, "undef_t0");

        // stop outside T2 is ignored
        cyc(1'b1, 1'b1, RDY, I_ADD, X_T1, "stop_early_t1");
        cyc(1'b1, 1'b1, RDY, I_ADD, X_T2, "stop_early_t2");
        step(I_ADD, X_T3R, "stop_early_t3");
        step(I_ADD, X_T4R | A_ADD, "stop_early_t4");
        step(I_ADD, X_WB, "stop_early_t5");
        step(I_ADD, X_T0, "stop_early_t0");

        fetch(I_ADD, "stop");
        cyc(1'b1, 1'b1, RDY, I_ADD, 26'd0, "stop_halt");
        step(I_ADD, 26'd0, "stop_halt_hold");
        step(I_ADD, 26'd0, "stop_halt_hold2");

        cyc(1'b0, 1'b0, RDY, I_ADD, 26'd0, "rst_from_halt");
        step(I_ADD, X_T0, "rst_from_halt_t0");
        fetch(I_ADD, "mid");
        step(I_ADD, X_T3R, "mid_t3");
        step(I_ADD, X_T4R | A_ADD, "mid_t4");
        cyc(1'b0, 1'b0, RDY, I_ADD, 26'd0, "rst_mid_t4");
        step(I_NOP, X_T0, "mid_rst_t0");
        fetch(I_NOP, "clean");
        step(I_NOP, X_T0, "clean_t0");

        fetch(I_HALT, "halt");
        step(I_HALT, 26'd0, "halt_state");
        step(I_NOP,  26'd0, "halt_hold");
        cyc(1'b0, 1'b0, RDY, I_NOP, 26'd0, "rst_after_halt");
        step(I_NOP, X_T0, "rst_after_halt_t0");

`ifdef CTRL_MEM_WAIT_EN
        cyc(1'b1, 1'b0, 1'b0, I_NOP, X_T1, "to_t1");
        for (int i = 0; i < 15; i++)
            cyc(1'b1, 1'b0, 1'b0, I_NOP, X_T1, "to_wait");
        cyc(1'b1, 1'b0, 1'b0, I_NOP, E_ERR, "to_halt");
        cyc(1'b1, 1'b0, 1'b1, I_NOP, E_ERR, "to_err_sticky");
        cyc(1'b0, 1'b0, 1'b1, I_NOP, 26'd0, "to_rst_clear");
        cyc(1'b1, 1'b0, 1'b1, I_NOP, X_T0, "to_rst_t0");
`endif

        repeat (2) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
